// File: rtl/binv_initiator_if.sv
// ============================================================================
// Module      : binv_initiator_if
// Description : Eviction, completion and per-L1 invalidate signal bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface binv_initiator_if #(
   parameter int NUM_L1    = 2,
   parameter int LINE_BITS = 256
);
   logic                        evict_valid;
   logic                        evict_ready;
   logic [31:0]                 evict_addr;

   logic                        done_valid;
   logic                        done_ready;
   logic [31:0]                 done_addr;
   logic [LINE_BITS-1:0]        done_data;
   logic                        done_any;

   logic [NUM_L1-1:0]           invalidate_req;
   logic [31:0]                 invalidate_addr;
   logic [NUM_L1-1:0]           invalidate_resp;
   logic [NUM_L1*LINE_BITS-1:0] invalidate_wdata;

   // Initiator side.
   modport master (
      input  evict_valid, evict_addr, done_ready, invalidate_resp, invalidate_wdata,
      output evict_ready, done_valid, done_addr, done_data, done_any,
             invalidate_req, invalidate_addr
   );

   // Shared cache and L1 side.
   modport slave (
      output evict_valid, evict_addr, done_ready, invalidate_resp, invalidate_wdata,
      input  evict_ready, done_valid, done_addr, done_data, done_any,
             invalidate_req, invalidate_addr
   );
endinterface

`default_nettype wire

// File: rtl/binv_initiator.sv
// ============================================================================
// Module      : binv_initiator
// Description : Queues shared-cache evictions and back-invalidates every L1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module binv_initiator #(
   parameter int NUM_L1      = 2,
   parameter int QDEPTH      = 2,
   parameter int LINE_BITS   = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   binv_initiator_if.master bus
);

   localparam int          AW        = $clog2(QDEPTH);
   localparam int          PW        = AW + 1;
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e               state_q,      state_d;
   logic [PW-1:0]        wr_ptr_q,     wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q,     rd_ptr_d;
   logic [31:0]          fifo_q [QDEPTH];
   logic [NUM_L1-1:0]    req_q,        req_d;
   logic [31:0]          iaddr_q,      iaddr_d;
   logic [NUM_L1-1:0]    ack_q,        ack_d;
   logic [LINE_BITS-1:0] data_q,       data_d;
   logic                 any_q,        any_d;
   logic                 dvalid_q,     dvalid_d;
   logic [31:0]          daddr_q,      daddr_d;
   logic [LINE_BITS-1:0] ddata_q,      ddata_d;
   logic                 dany_q,       dany_d;

   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push_en;
   logic                 pop_en;
   logic [NUM_L1-1:0]    sampled;
   logic                 sel_hit;
   logic [LINE_BITS-1:0] sel_data;

   // Pointers carry one wrap bit above the index.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q == {~rd_ptr_q[PW-1], rd_ptr_q[AW-1:0]});
   assign push_en    = bus.evict_valid && !fifo_full;
   assign pop_en     = (state_q == S_IDLE) && !fifo_empty;

   // Acknowledges on channels whose request has already dropped are ignored.
   assign sampled    = bus.invalidate_resp & req_q;

   // Lowest-index sampled acknowledge supplies the candidate line data.
   always_comb begin
      sel_hit  = 1'b0;
      sel_data = '0;
      for (int i = NUM_L1 - 1; i >= 0; i--) begin
         if (sampled[i]) begin
            sel_hit  = 1'b1;
            sel_data = bus.invalidate_wdata[i*LINE_BITS +: LINE_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= bus.evict_addr & LINE_MASK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         req_q    <= '0;
         iaddr_q  <= '0;
         ack_q    <= '0;
         data_q   <= '0;
         any_q    <= 1'b0;
         dvalid_q <= 1'b0;
         daddr_q  <= '0;
         ddata_q  <= '0;
         dany_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         req_q    <= req_d;
         iaddr_q  <= iaddr_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         any_q    <= any_d;
         dvalid_q <= dvalid_d;
         daddr_q  <= daddr_d;
         ddata_q  <= ddata_d;
         dany_q   <= dany_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_en};
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_en};
      req_d    = req_q;
      iaddr_d  = iaddr_q;
      ack_d    = ack_q;
      data_d   = data_q;
      any_d    = any_q;
      dvalid_d = dvalid_q;
      daddr_d  = daddr_q;
      ddata_d  = ddata_q;
      dany_d   = dany_q;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_WAIT;
               iaddr_d = fifo_q[rd_ptr_q[AW-1:0]];
               req_d   = '1;
               ack_d   = '0;
               data_d  = '0;
               any_d   = 1'b0;
            end
         end
         S_WAIT: begin
            ack_d = ack_q | sampled;
            req_d = req_q & ~sampled;
            // Only the first acknowledging L1 provides the returned line.
            if (sel_hit && !any_q) begin
               data_d = sel_data;
               any_d  = 1'b1;
            end
            if (ack_d == '1) begin
               state_d  = S_DONE;
               dvalid_d = 1'b1;
               daddr_d  = iaddr_q;
               ddata_d  = data_d;
               dany_d   = any_d;
            end
         end
         S_DONE: begin
            if (bus.done_ready) begin
               state_d  = S_IDLE;
               dvalid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.evict_ready     = !fifo_full;
   assign bus.invalidate_req  = req_q;
   assign bus.invalidate_addr = iaddr_q;
   assign bus.done_valid      = dvalid_q;
   assign bus.done_addr       = daddr_q;
   assign bus.done_data       = ddata_q;
   assign bus.done_any        = dany_q;

endmodule

`default_nettype wire

// File: tb/tb_binv_initiator.sv
// ============================================================================
// Module      : tb_binv_initiator
// Description : Directed table rounds, corner sequences and random traffic.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_binv_initiator;
   localparam int NUM_L1      = 2;
   localparam int QDEPTH      = 2;
   localparam int LINE_BITS   = 256;
   localparam int OFFSET_BITS = 5;
   localparam logic [31:0] MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   binv_initiator_if #(.NUM_L1(NUM_L1), .LINE_BITS(LINE_BITS)) bus ();

   binv_initiator #(
      .NUM_L1(NUM_L1), .QDEPTH(QDEPTH), .LINE_BITS(LINE_BITS), .OFFSET_BITS(OFFSET_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          d0;
      int          d1;
      logic [31:0] exp_addr;
      int          exp_win;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input logic [LINE_BITS-1:0] act, input logic [LINE_BITS-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_BITS-1:0] rnd_line();
      logic [LINE_BITS-1:0] v;
      for (int w = 0; w < LINE_BITS / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: queue of pending lines plus the outstanding set of the round.
   logic [31:0]          m_q [$];
   logic [NUM_L1-1:0]    m_out;
   bit                   m_in_round, m_done_pend, m_got, m_dany;
   logic [31:0]          m_iaddr, m_daddr;
   logic [LINE_BITS-1:0] m_data, m_ddata;

   always @(posedge clk) begin
      logic [NUM_L1-1:0] smp;
      bit                do_start, do_push;
      if (rst) begin
         m_q.delete();
         m_out = '0; m_in_round = 0; m_done_pend = 0; m_got = 0; m_dany = 0;
         m_iaddr = '0; m_daddr = '0; m_data = '0; m_ddata = '0;
      end else begin
         do_start = !m_in_round && !m_done_pend && (m_q.size() > 0);
         do_push  = bus.evict_valid && (m_q.size() < QDEPTH);
         if (m_in_round) begin
            smp = bus.invalidate_resp & m_out;
            if (!m_got && smp != '0) begin
               for (int i = 0; i < NUM_L1; i++) begin
                  if (smp[i]) begin
                     m_data = bus.invalidate_wdata[i*LINE_BITS +: LINE_BITS];
                     break;
                  end
               end
               m_got = 1;
            end
            m_out = m_out & ~smp;
            if (m_out == '0) begin
               m_in_round = 0; m_done_pend = 1;
               m_daddr = m_iaddr; m_ddata = m_data; m_dany = 1;
            end
         end else if (m_done_pend && bus.done_ready) begin
            m_done_pend = 0;
         end
         if (do_start) begin
            m_iaddr = m_q.pop_front();
            m_in_round = 1; m_out = '1; m_got = 0; m_data = '0;
         end
         if (do_push) m_q.push_back(bus.evict_addr & MASK);
      end
      #1;
      chk("mdl_evict_ready", bus.evict_ready, m_q.size() < QDEPTH);
      chk("mdl_req", bus.invalidate_req, m_in_round ? m_out : '0);
      chk("mdl_iaddr", bus.invalidate_addr, m_iaddr);
      chk("mdl_done_valid", bus.done_valid, m_done_pend);
      chk("mdl_done_addr", bus.done_addr, m_daddr);
      chk("mdl_done_data", bus.done_data, m_ddata);
      chk("mdl_done_any", bus.done_any, m_dany);
   end

   task automatic wait_req();
      for (int n = 0; n < 10 && bus.invalidate_req != '1; n++) tick();
      chk("issue_timeout", bus.invalidate_req, {NUM_L1{1'b1}});
   endtask

   task automatic push(input logic [31:0] a);
      bus.evict_valid = 1'b1;
      bus.evict_addr  = a;
      tick();
      bus.evict_valid = 1'b0;
   endtask

   // All L1s acknowledge together; slice 0 must win.
   task automatic finish_round(input logic [31:0] exp_addr);
      logic [LINE_BITS-1:0] d [NUM_L1];
      wait_req();
      chk("fr_iaddr", bus.invalidate_addr, exp_addr);
      for (int i = 0; i < NUM_L1; i++) begin
         d[i] = rnd_line();
         bus.invalidate_wdata[i*LINE_BITS +: LINE_BITS] = d[i];
      end
      bus.invalidate_resp = '1;
      tick();
      bus.invalidate_resp = '0;
      chk("fr_done_valid", bus.done_valid, 1'b1);
      chk("fr_done_addr", bus.done_addr, exp_addr);
      chk("fr_done_data", bus.done_data, d[0]);
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
   endtask

   // Table round: channel i acks dly_i cycles after req rises, then keeps
   // pulsing spurious acks with junk data until the round ends.
   task automatic do_round(input vec_t v);
      logic [LINE_BITS-1:0] d [NUM_L1];
      int                   dly [NUM_L1];
      int                   mx;
      logic [NUM_L1-1:0]    exp_req;
      dly[0] = v.d0;
      dly[1] = v.d1;
      mx = (v.d0 > v.d1) ? v.d0 : v.d1;
      for (int i = 0; i < NUM_L1; i++) d[i] = rnd_line();
      push(v.addr);
      chk("tb_req_idle", bus.invalidate_req, '0);
      tick();
      chk("tb_req_issue", bus.invalidate_req, {NUM_L1{1'b1}});
      chk("tb_iaddr", bus.invalidate_addr, v.exp_addr);
      for (int k = 0; k <= mx; k++) begin
         for (int i = 0; i < NUM_L1; i++) begin
            bus.invalidate_resp[i] = (k >= dly[i]);
            bus.invalidate_wdata[i*LINE_BITS +: LINE_BITS] = (k == dly[i]) ? d[i] : rnd_line();
            exp_req[i] = (dly[i] > k);
         end
         tick();
         chk("tb_req_drop", bus.invalidate_req, exp_req);
         chk("tb_done_timing", bus.done_valid, k == mx);
         chk("tb_iaddr_hold", bus.invalidate_addr, v.exp_addr);
      end
      bus.invalidate_resp = '0;
      chk("tb_done_addr", bus.done_addr, v.exp_addr);
      chk("tb_done_data", bus.done_data, d[v.exp_win]);
      chk("tb_done_any", bus.done_any, 1'b1);
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      chk("tb_done_clear", bus.done_valid, 1'b0);
   endtask

   initial begin
      logic [31:0]          a [4];
      logic [LINE_BITS-1:0] hold_data;

      tbl[0] = '{addr: 32'h1234_5678, d0: 1, d1: 1, exp_addr: 32'h1234_5660, exp_win: 0};
      tbl[1] = '{addr: 32'hDEAD_BEEF, d0: 4, d1: 1, exp_addr: 32'hDEAD_BEE0, exp_win: 1};
      tbl[2] = '{addr: 32'h0000_001F, d0: 0, d1: 2, exp_addr: 32'h0000_0000, exp_win: 0};
      tbl[3] = '{addr: 32'hFFFF_FFE0, d0: 3, d1: 3, exp_addr: 32'hFFFF_FFE0, exp_win: 0};
      tbl[4] = '{addr: 32'h8000_0021, d0: 2, d1: 0, exp_addr: 32'h8000_0020, exp_win: 1};

      bus.evict_valid = 1'b0; bus.evict_addr = '0; bus.done_ready = 1'b0;
      bus.invalidate_resp = '0; bus.invalidate_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_req", bus.invalidate_req, '0);
      chk("rst_evict_ready", bus.evict_ready, 1'b1);
      chk("rst_done_valid", bus.done_valid, 1'b0);

      foreach (tbl[j]) do_round(tbl[j]);

      // Back-pressure: A is popped, B and C fill the FIFO, D waits.
      for (int i = 0; i < 4; i++) a[i] = 32'h4000_0000 + i * 32'h100 + 32'h7;
      bus.evict_valid = 1'b1;
      bus.evict_addr = a[0]; tick();
      bus.evict_addr = a[1]; tick();
      bus.evict_addr = a[2]; tick();
      chk("bp_full", bus.evict_ready, 1'b0);
      bus.evict_addr = a[3];
      repeat (2) tick();
      chk("bp_still_full", bus.evict_ready, 1'b0);
      hold_data = rnd_line();
      bus.invalidate_wdata = {NUM_L1{hold_data}};
      bus.invalidate_resp = '1;
      tick();
      bus.invalidate_resp = '0;
      chk("bp_done", bus.done_valid, 1'b1);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("bp_hold_valid", bus.done_valid, 1'b1);
         chk("bp_hold_addr", bus.done_addr, a[0] & MASK);
         chk("bp_hold_data", bus.done_data, hold_data);
      end
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      chk("bp_accept", bus.done_valid, 1'b0);
      chk("bp_bubble", bus.invalidate_req, '0);
      tick();
      chk("bp_next_req", bus.invalidate_req, {NUM_L1{1'b1}});
      chk("bp_next_addr", bus.invalidate_addr, a[1] & MASK);
      chk("bp_space", bus.evict_ready, 1'b1);
      tick();
      bus.evict_valid = 1'b0;
      for (int i = 1; i < 4; i++) finish_round(a[i] & MASK);

      // Reset mid-WAIT with a second entry still queued.
      bus.evict_valid = 1'b1;
      bus.evict_addr = 32'h5555_5555; tick();
      bus.evict_addr = 32'h6666_6666; tick();
      bus.evict_valid = 1'b0;
      chk("rw_issue", bus.invalidate_req, {NUM_L1{1'b1}});
      bus.invalidate_resp = 2'b10;
      bus.invalidate_wdata = {rnd_line(), rnd_line()};
      tick();
      bus.invalidate_resp = '0;
      chk("rw_partial", bus.invalidate_req, 2'b01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_req", bus.invalidate_req, '0);
      chk("rw_iaddr", bus.invalidate_addr, '0);
      chk("rw_done_valid", bus.done_valid, 1'b0);
      chk("rw_done_data", bus.done_data, '0);
      chk("rw_evict_ready", bus.evict_ready, 1'b1);
      repeat (3) tick();
      chk("rw_discarded", bus.invalidate_req, '0);
      do_round(tbl[0]);

      // Six completed rounds wrap the QDEPTH=2 pointers several times.
      for (int i = 0; i < 6; i++) begin
         push(32'hA000_0000 + i * 32'h40 + i);
         finish_round((32'hA000_0000 + i * 32'h40) & MASK);
      end

      // Random traffic, checked cycle by cycle against the model.
      for (int c = 0; c < 400; c++) begin
         bus.evict_valid = ($urandom_range(0, 2) == 0);
         bus.evict_addr = $urandom;
         bus.done_ready = ($urandom_range(0, 1) == 1);
         bus.invalidate_resp = NUM_L1'($urandom);
         for (int i = 0; i < NUM_L1; i++)
            bus.invalidate_wdata[i*LINE_BITS +: LINE_BITS] = rnd_line();
         tick();
      end
      bus.evict_valid = 1'b0;
      bus.done_ready = 1'b1;
      bus.invalidate_resp = '1;
      repeat (12) tick();
      chk("drain_req", bus.invalidate_req, '0);
      chk("drain_done", bus.done_valid, 1'b0);
      chk("drain_ready", bus.evict_ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule

`default_nettype wire
